toggle_handshake_tx: RTL and testbench

Source end of the team's two-phase toggle req/ack clock-domain-crossing handshake. It accepts one data word per transfer from the local clock domain and toggles a level request. It holds the data stable on the crossing bus until the receiver's ack toggle returns, bringing ack in through an internal `STAGES`-deep flop chain. The receive side synchronizes `xfer_req` with the team's synchronizer and echoes it back as `xfer_ack`.

---
 rtl/toggle_handshake_tx.sv | 135 +++++++++++++
 tb/tb_toggle_handshake_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_tx.sv
// Source side of a two-phase toggle req/ack clock-domain-crossing handshake.
// One word per transfer: the request level toggles on accept, and the data stays
// frozen on the crossing bus until the synchronized ack level matches the request.
module toggle_handshake_tx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_data,
    output logic             send_ready,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             done,
    output logic             timeout_err
);

    // Counter counts up to TIMEOUT; at least one bit even when the timeout is disabled.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StErr     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [STAGES-1:0] ack_sync_q;
    logic              req_q, req_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic ack_s;
    logic ack_s_next;
    logic match;
    logic match_next;

    // Ack synchronizer: the only place xfer_ack is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[STAGES-2:0], xfer_ack};
        end
    end

    assign ack_s      = ack_sync_q[STAGES-1];
    // Value ack_s takes on the coming edge; completion is decided on it so that
    // done and the return of send_ready land in the same cycle as the ack_s change.
    assign ack_s_next = ack_sync_q[STAGES-2];
    assign match      = (ack_s == req_q);
    assign match_next = (ack_s_next == req_q);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and the combinational ready.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = err_q;
        send_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A stray ack toggle leaves match low, holding off new words.
                send_ready = match;
                if (send_valid && match) begin
                    req_d   = ~req_q;
                    data_d  = send_data;
                    cnt_d   = '0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Ack arrival wins over a timeout on the same edge.
                if (match_next) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end
            end
            StErr: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Late ack recovers silently: no done pulse for an overdue transfer.
                if (match_next) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign xfer_req    = req_q;
    assign xfer_data   = data_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// Bench for toggle_handshake_tx: directed scenarios plus randomized traffic, all
// checked every cycle against a transfer-level reference model.
module tb_toggle_handshake_tx;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         send_valid;
    logic [W-1:0] send_data;
    logic         send_ready;
    logic         xfer_req;
    logic [W-1:0] xfer_data;
    logic         xfer_ack;
    logic         done;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toggle_handshake_tx #(
        .WIDTH  (W),
        .STAGES (S),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .done       (done),
        .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Tracks the transfer by elapsed edges since accept; ack seen by the block is
    // the xfer_ack level from S-1 edges back (h[S-1]), and h[S-2] is what it becomes.
    int           m_edge  = 0;
    int           m_tacc  = 0;
    logic         m_req   = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_busy  = 1'b0;
    logic         m_err   = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_acc   = 1'b0;
    logic [S-1:0] m_h     = '0;
    logic         m_pre;
    logic         m_post;
    bit           model_on = 1'b0;

    always @(posedge clk) begin
        m_edge++;
        m_acc  = 1'b0;
        m_done = 1'b0;
        if (!reset_n) begin
            m_req  = 1'b0;
            m_data = '0;
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_h    = '0;
        end else begin
            m_pre  = m_h[S-1];
            m_post = m_h[S-2];
            if (!m_busy && !m_err) begin
                if (send_valid && (m_pre == m_req)) begin
                    m_req  = ~m_req;
                    m_data = send_data;
                    m_busy = 1'b1;
                    m_tacc = m_edge;
                    m_acc  = 1'b1;
                end
            end else if (m_busy) begin
                if (m_post == m_req) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end else if (m_edge - m_tacc >= TO) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (m_post == m_req) begin
                m_err = 1'b0;
            end
            m_h = {m_h[S-2:0], xfer_ack};
        end
        #1;
        if (model_on) begin
            check_eq("model_req", xfer_req, m_req);
            check_eq("model_data", xfer_data, m_data);
            check_eq("model_done", done, m_done);
            check_eq("model_err", timeout_err, m_err);
            check_eq("model_ready", send_ready, !m_busy && !m_err && (m_h[S-1] == m_req));
        end
    end

    // ---------------- receiver ----------------
    // 0: ack driven by the bench, 1: immediate echo, 2: echo after a random delay.
    int rx_mode = 0;
    int rx_cnt  = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_mode == 1) begin
                xfer_ack = xfer_req;
            end else if (rx_mode == 2) begin
                if (xfer_ack != xfer_req) begin
                    if (rx_cnt == 0) begin
                        xfer_ack = xfer_req;
                        rx_cnt   = $urandom_range(0, 20);
                    end else begin
                        rx_cnt--;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        send_valid = 1'b0;
        rx_mode    = 0;
        xfer_ack   = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        send_valid = 1'b0;
        send_data  = '0;
        xfer_ack   = 1'b0;
        tick();
        model_on = 1'b1;
        tick();
        reset_n = 1'b1;

        // Reset state
        check_eq("rst_ready", send_ready, 1);
        check_eq("rst_req", xfer_req, 0);
        check_eq("rst_data", xfer_data, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", timeout_err, 0);

        // Single transfer, loopback
        rx_mode    = 1;
        send_data  = 8'hA5;
        send_valid = 1'b1;
        tick();
        check_eq("single_req", xfer_req, 1);
        check_eq("single_data", xfer_data, 8'hA5);
        check_eq("single_busy", send_ready, 0);
        send_valid = 1'b0;
        tick();
        check_eq("single_done_early", done, 0);
        tick();
        check_eq("single_done", done, 1);
        check_eq("single_ready", send_ready, 1);
        tick();
        check_eq("single_done_pulse", done, 0);

        // Back-to-back, send_valid held
        do_reset();
        rx_mode    = 1;
        send_valid = 1'b1;
        send_data  = 8'h01;
        tick();
        check_eq("b2b_req1", xfer_req, 1);
        check_eq("b2b_data1", xfer_data, 8'h01);
        send_data = 8'h02;
        tick();
        check_eq("b2b_hold1", xfer_data, 8'h01);
        check_eq("b2b_nodone", done, 0);
        tick();
        check_eq("b2b_hold1b", xfer_data, 8'h01);
        check_eq("b2b_done1", done, 1);
        tick();
        check_eq("b2b_req2", xfer_req, 0);
        check_eq("b2b_data2", xfer_data, 8'h02);
        check_eq("b2b_done_off", done, 0);
        send_data = 8'h03;
        tick();
        tick();
        check_eq("b2b_hold2", xfer_data, 8'h02);
        check_eq("b2b_done2", done, 1);
        tick();
        check_eq("b2b_req3", xfer_req, 1);
        check_eq("b2b_data3", xfer_data, 8'h03);
        send_valid = 1'b0;
        tick();
        tick();
        check_eq("b2b_done3", done, 1);
        tick();
        check_eq("b2b_idle_req", xfer_req, 1);

        // Timeout with ack stuck low, then late ack
        do_reset();
        send_valid = 1'b1;
        send_data  = 8'h3C;
        tick();
        check_eq("to_req", xfer_req, 1);
        send_valid = 1'b0;
        repeat (15) tick();
        check_eq("to_err_early", timeout_err, 0);
        tick();
        check_eq("to_err", timeout_err, 1);
        check_eq("to_ready", send_ready, 0);
        check_eq("to_done", done, 0);
        repeat (3) tick();
        check_eq("to_err_sticky", timeout_err, 1);
        xfer_ack = 1'b1;
        tick();
        check_eq("to_err_hold", timeout_err, 1);
        tick();
        check_eq("to_err_clr", timeout_err, 0);
        check_eq("to_ready_back", send_ready, 1);
        check_eq("to_late_nodone", done, 0);

        // Spurious ack toggle in idle
        do_reset();
        tick();
        check_eq("sp_ready0", send_ready, 1);
        xfer_ack = 1'b1;
        tick();
        check_eq("sp_ready1", send_ready, 1);
        tick();
        check_eq("sp_ready_drop", send_ready, 0);
        send_valid = 1'b1;
        send_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("sp_no_accept", xfer_req, 0);
        end
        xfer_ack = 1'b0;
        tick();
        check_eq("sp_still_off", send_ready, 0);
        tick();
        check_eq("sp_ready_back", send_ready, 1);
        check_eq("sp_req_back", xfer_req, 0);
        tick();
        check_eq("sp_accept_req", xfer_req, 1);
        check_eq("sp_accept_data", xfer_data, 8'h77);
        send_valid = 1'b0;
        rx_mode    = 1;
        tick();
        tick();
        check_eq("sp_done", done, 1);

        // Reset while awaiting ack
        do_reset();
        rx_mode    = 1;
        send_valid = 1'b1;
        send_data  = 8'h5A;
        tick();
        check_eq("mr_data", xfer_data, 8'h5A);
        send_valid = 1'b0;
        reset_n    = 1'b0;
        rx_mode    = 0;
        xfer_ack   = 1'b0;
        tick();
        check_eq("mr_req", xfer_req, 0);
        check_eq("mr_data0", xfer_data, 0);
        check_eq("mr_ready", send_ready, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mr_nodone", done, 0);
            check_eq("mr_noerr", timeout_err, 0);
        end

        // Randomized traffic with a delayed, occasionally misbehaving receiver
        do_reset();
        rx_mode = 2;
        rx_cnt  = 0;
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_n    = 1'b0;
                send_valid = 1'b0;
                xfer_ack   = 1'b0;
                rx_cnt     = 0;
            end else begin
                reset_n = 1'b1;
                if (!(send_valid && !m_acc)) begin
                    send_valid = ($urandom_range(0, 2) == 0);
                    if (send_valid) send_data = W'($urandom);
                end
                if ($urandom_range(0, 249) == 0) xfer_ack = ~xfer_ack;
            end
            tick();
        end

        reset_n    = 1'b1;
        rx_mode    = 0;
        send_valid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
